execute_stage3: RTL
===================

# execute_stage3

Stage-3 execute/memory block of the 24-bit pipeline. It consumes the stage-2/3 register outputs and performs the ALU operation and branch resolution. It runs data-memory loads and stores and stack push/pop through a req/ack memory port, and drives registered stage-4 writeback outputs. While a memory access is outstanding it raises `stall`, which freezes stages 1–3, including the stage-2/3 register enable.

## Interface
- `STACK_BASE`, default 10'h3FF: reset and empty value of the stack pointer.
- `STACK_LIMIT`, default 10'h300: lowest address a push may write.
- `clk` in 1: the single clock; all state is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `branch3, load3, store3, pop3, push3` in 1 each: stage-3 control.
- `aluOp3` in 4: ALU operation.
- `RT3` in 4: destination register.
- `address3` in 10: memory address or branch target (target = `address3[8:0]`).
- `pcInc3` in 9: PC+1 of the instruction.
- `A3, B3` in 24 each: operands.
- `memRdata` in 24: read data.
- `memAck` in 1: access complete.
- `memReq` out 1: access request.
- `memWe` out 1: 1 = write.
- `memAddr` out 10: access address.
- `memWdata` out 24: write data.
- `stall` out 1: hold upstream stages.
- `wbEn4` out 1: writeback enable.
- `RT4` out 4: writeback register.
- `result4` out 24: writeback data.
- `branchTaken4` out 1: one-cycle flush/redirect pulse.
- `branchTarget4` out 9: redirect PC.
- `stackFault4` out 1: one-cycle overflow/underflow pulse.
- `sp` out 10: current stack pointer.

## Operation
- ALU, aluOp3:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SHL A by `B3[4:0]`, 6 SHR logical A by `B3[4:0]`; shift amounts ≥24 yield 0.
  - 7 PASS B.
  - 8 SLT signed, result 24'd1 or 0.
  - Codes 9–15 yield 0.
  - All arithmetic is mod 2^24 with no flags.
- Non-memory, non-branch instruction: stage-4 outputs load `result4` = ALU result, `RT4` = RT3 and `wbEn4` = 1 if `RT3 != 0` (R0 is never written).
- Branch: taken when A3 == B3. If taken, `branchTaken4` = 1 and `branchTarget4` = `address3[8:0]`.
  - If taken and RT3 != 0, it also writes the link value {15'b0, pcInc3}.
  - If not taken, `wbEn4` = 0.
- Memory op decode priority: push > pop > load > store. Lower-priority flags set in the same cycle are ignored.
- FSM states:
  - IDLE: with no memory op, results are registered every cycle. A memory op latches `memAddr`, `memWe` and `memWdata`, moves to ACCESS, and asserts `stall` combinationally in that cycle.
  - ACCESS: `memReq` = 1 with address, we and wdata held stable. `stall` = !memAck. On memAck the FSM returns to IDLE. For a load or pop, `result4` = memRdata and `wbEn4` = (RT3 != 0). For a store or push, `wbEn4` = 0.
- memAck is ignored in IDLE.
- Push: write B3 at `sp`; `sp` ← sp−1 on ack.
  - If sp < STACK_LIMIT, there is no access and no stall: `stackFault4` pulses and the push acts as a NOP.
- Pop: read at sp+1; `sp` ← sp+1 on ack.
  - If sp == STACK_BASE, there is no access: `stackFault4` pulses and `wbEn4` = 0.
- Stage-4 outputs are zeroed (bubble) on every cycle that `stall` = 1.

## Timing
- Reset (asynchronous, immediate): FSM → IDLE. `memReq`, `memWe`, `wbEn4`, `branchTaken4` and `stackFault4` go to 0. `memAddr`, `memWdata`, `RT4`, `result4` and `branchTarget4` go to 0. `sp` = STACK_BASE.
- `stall` is forced 0 while rst is high.
- Reset during ACCESS abandons the access: `memReq` drops in the same cycle and no writeback or sp update occurs.
- Latency:
  - ALU and branch ops: 1 cycle (inputs at edge N, stage-4 outputs valid after edge N+1).
  - Memory ops: 2 + W cycles, where W is the number of ACCESS cycles without ack. The minimum is 2 with ack in the first ACCESS cycle.
- Upstream inputs must stay stable while `stall` = 1.
- `branchTaken4` and `stackFault4` are high for exactly one cycle per event.

## Configuration
- `RK_STACK_EN` defined: push/pop, `sp` and `stackFault4` behave as described.
- `RK_STACK_EN` undefined: push3 and pop3 are ignored and their instructions act as NOPs with no writeback. `sp` is tied to STACK_BASE, `stackFault4` is tied to 0, and no stack logic is synthesized.

## Structure
- Package `rk_pkg`:
  - ALU op code constants (ALU_ADD … ALU_SLT).
  - FSM state typedef {IDLE, ACCESS}.
  - Width constants DATA_W=24, ADDR_W=10, PC_W=9, REG_W=4.
- Sub-module `rk_alu`: combinational, inputs aluOp/A/B, output result.

## Test plan
- ADD A=24'hFFFFFF, B=1, RT3=3 → next cycle `result4`=0, `wbEn4`=1, `RT4`=3. The same with RT3=0 → `wbEn4`=0.
- Branch A=B=5, address3=10'h045, pcInc3=9'h012, RT3=15 → `branchTaken4`=1 for one cycle, `branchTarget4`=9'h045, `result4`=24'h000012.
- Load from address 10'h010, memAck after 3 wait cycles, memRdata=24'hABCDEF → `stall` high for 4 cycles, `memReq` held with stable addr, then `result4`=24'hABCDEF.
- Push B=7 then pop into RT3=2 → write to 10'h3FF, sp=10'h3FE, read 10'h3FF, `result4`=7, sp back to 10'h3FF.
- Pop at sp=STACK_BASE → `stackFault4` pulse, `memReq` stays 0, `wbEn4`=0, sp unchanged.
- rst asserted in the second ACCESS cycle of a store → `memReq` drops immediately, sp and outputs at reset values. A later memAck in IDLE is ignored.

Source files
------------

// File: rtl/rk_pkg.sv
// Shared constants and types for the stage-3 execute/memory block.
package rk_pkg;

   localparam int DATA_W = 24;
   localparam int ADDR_W = 10;
   localparam int PC_W   = 9;
   localparam int REG_W  = 4;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SHL  = 4'd5;
   localparam logic [3:0] ALU_SHR  = 4'd6;
   localparam logic [3:0] ALU_PASS = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;

   typedef enum logic {IDLE, ACCESS} state_t;

   typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_PUSH, OP_POP} mem_op_t;

endpackage

// File: rtl/rk_alu.sv
// Combinational 24-bit ALU; undefined op codes and oversize shifts produce zero.
module rk_alu
   import rk_pkg::*;
(
   input  logic [3:0]        aluOp,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] result
);

   logic signed [DATA_W-1:0] a_s;
   logic signed [DATA_W-1:0] b_s;
   logic [4:0]               shamt;

   assign a_s   = A;
   assign b_s   = B;
   assign shamt = B[4:0];

   always_comb begin
      result = '0;
      case (aluOp)
         ALU_ADD:  result = A + B;
         ALU_SUB:  result = A - B;
         ALU_AND:  result = A & B;
         ALU_OR:   result = A | B;
         ALU_XOR:  result = A ^ B;
         ALU_SHL:  result = (shamt >= 5'd24) ? '0 : (A << shamt);
         ALU_SHR:  result = (shamt >= 5'd24) ? '0 : (A >> shamt);
         ALU_PASS: result = B;
         ALU_SLT:  result = (a_s < b_s) ? DATA_W'(1) : '0;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/execute_stage3.sv
// Stage-3 execute/memory: ALU, branch resolution, req/ack memory port, stage-4 writeback regs.
// Stack push/pop support is built only when RK_STACK_EN is defined.
module execute_stage3
   import rk_pkg::*;
#(
   parameter logic [ADDR_W-1:0] STACK_BASE  = 10'h3FF,
   parameter logic [ADDR_W-1:0] STACK_LIMIT = 10'h300
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              branch3,
   input  logic              load3,
   input  logic              store3,
   input  logic              pop3,
   input  logic              push3,
   input  logic [3:0]        aluOp3,
   input  logic [REG_W-1:0]  RT3,
   input  logic [ADDR_W-1:0] address3,
   input  logic [PC_W-1:0]   pcInc3,
   input  logic [DATA_W-1:0] A3,
   input  logic [DATA_W-1:0] B3,
   input  logic [DATA_W-1:0] memRdata,
   input  logic              memAck,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   output logic              stall,
   output logic              wbEn4,
   output logic [REG_W-1:0]  RT4,
   output logic [DATA_W-1:0] result4,
   output logic              branchTaken4,
   output logic [PC_W-1:0]   branchTarget4,
   output logic              stackFault4,
   output logic [ADDR_W-1:0] sp
);

   if (STACK_LIMIT > STACK_BASE) begin : g_bad_cfg
      $error("STACK_LIMIT must not exceed STACK_BASE");
   end

   state_t              state_q, state_d;
   mem_op_t             op_q, op_d;
   logic [REG_W-1:0]    rt_q, rt_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_we_q, mem_we_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                wb_en4_q, wb_en4_d;
   logic [REG_W-1:0]    rt4_q, rt4_d;
   logic [DATA_W-1:0]   result4_q, result4_d;
   logic                br_taken4_q, br_taken4_d;
   logic [PC_W-1:0]     br_target4_q, br_target4_d;
   logic                stack_fault4_q, stack_fault4_d;
   logic                stall_c;
   logic [DATA_W-1:0]   alu_result;
`ifdef RK_STACK_EN
   logic [ADDR_W-1:0]   sp_q, sp_d;
`endif

   rk_alu u_alu (
      .aluOp  (aluOp3),
      .A      (A3),
      .B      (B3),
      .result (alu_result)
   );

   // Stage-4 defaults are a bubble, so any stalled cycle registers zeros.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      rt_d           = rt_q;
      mem_addr_d     = mem_addr_q;
      mem_we_d       = mem_we_q;
      mem_wdata_d    = mem_wdata_q;
      wb_en4_d       = 1'b0;
      rt4_d          = '0;
      result4_d      = '0;
      br_taken4_d    = 1'b0;
      br_target4_d   = '0;
      stack_fault4_d = 1'b0;
      stall_c        = 1'b0;
`ifdef RK_STACK_EN
      sp_d           = sp_q;
`endif
      case (state_q)
         IDLE: begin
            if (push3 || pop3) begin
`ifdef RK_STACK_EN
               if (push3) begin
                  if (sp_q < STACK_LIMIT) begin
                     stack_fault4_d = 1'b1;
                  end else begin
                     state_d     = ACCESS;
                     op_d        = OP_PUSH;
                     rt_d        = RT3;
                     mem_addr_d  = sp_q;
                     mem_we_d    = 1'b1;
                     mem_wdata_d = B3;
                     stall_c     = 1'b1;
                  end
               end else if (sp_q == STACK_BASE) begin
                  stack_fault4_d = 1'b1;
               end else begin
                  state_d    = ACCESS;
                  op_d       = OP_POP;
                  rt_d       = RT3;
                  mem_addr_d = sp_q + ADDR_W'(1);
                  mem_we_d   = 1'b0;
                  stall_c    = 1'b1;
               end
`endif
            end else if (load3) begin
               state_d    = ACCESS;
               op_d       = OP_LOAD;
               rt_d       = RT3;
               mem_addr_d = address3;
               mem_we_d   = 1'b0;
               stall_c    = 1'b1;
            end else if (store3) begin
               state_d     = ACCESS;
               op_d        = OP_STORE;
               rt_d        = RT3;
               mem_addr_d  = address3;
               mem_we_d    = 1'b1;
               mem_wdata_d = B3;
               stall_c     = 1'b1;
            end else if (branch3) begin
               rt4_d     = RT3;
               result4_d = {{(DATA_W-PC_W){1'b0}}, pcInc3};
               if (A3 == B3) begin
                  br_taken4_d  = 1'b1;
                  br_target4_d = address3[PC_W-1:0];
                  wb_en4_d     = (RT3 != '0);
               end
            end else begin
               rt4_d     = RT3;
               result4_d = alu_result;
               wb_en4_d  = (RT3 != '0);
            end
         end
         ACCESS: begin
            if (memAck) begin
               state_d = IDLE;
               if (op_q == OP_LOAD || op_q == OP_POP) begin
                  rt4_d     = rt_q;
                  result4_d = memRdata;
                  wb_en4_d  = (rt_q != '0);
               end
`ifdef RK_STACK_EN
               if (op_q == OP_PUSH) sp_d = sp_q - ADDR_W'(1);
               if (op_q == OP_POP)  sp_d = sp_q + ADDR_W'(1);
`endif
            end else begin
               stall_c = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         op_q           <= OP_LOAD;
         rt_q           <= '0;
         mem_addr_q     <= '0;
         mem_we_q       <= 1'b0;
         mem_wdata_q    <= '0;
         wb_en4_q       <= 1'b0;
         rt4_q          <= '0;
         result4_q      <= '0;
         br_taken4_q    <= 1'b0;
         br_target4_q   <= '0;
         stack_fault4_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         rt_q           <= rt_d;
         mem_addr_q     <= mem_addr_d;
         mem_we_q       <= mem_we_d;
         mem_wdata_q    <= mem_wdata_d;
         wb_en4_q       <= wb_en4_d;
         rt4_q          <= rt4_d;
         result4_q      <= result4_d;
         br_taken4_q    <= br_taken4_d;
         br_target4_q   <= br_target4_d;
         stack_fault4_q <= stack_fault4_d;
      end
   end

`ifdef RK_STACK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sp_q <= STACK_BASE;
      else     sp_q <= sp_d;
   end
   assign sp = sp_q;
`else
   assign sp = STACK_BASE;
`endif

   // Request follows the FSM state directly so an async reset withdraws it at once.
   assign memReq        = (state_q == ACCESS);
   assign stall         = stall_c & ~rst;
   assign memWe         = mem_we_q;
   assign memAddr       = mem_addr_q;
   assign memWdata      = mem_wdata_q;
   assign wbEn4         = wb_en4_q;
   assign RT4           = rt4_q;
   assign result4       = result4_q;
   assign branchTaken4  = br_taken4_q;
   assign branchTarget4 = br_target4_q;
   assign stackFault4   = stack_fault4_q;

endmodule
